pipe_stage_skid_reg: RTL and testbench

//  Parametrised inter-stage pipeline register (MEM/WB and the other stage boundaries) with valid/ready

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_payload_reg.sv | 32 +++
 rtl/pipe_stage_skid_reg.sv | 139 +++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encodings and payload sizing for the pipeline stage register
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    function automatic int payload_w(int reg_w, int ctrl_w, int num_ch, int data_w);
        return reg_w + ctrl_w + num_ch * data_w;
    endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// rtl/pipe_payload_reg.sv - load-enable payload register with synchronous clear
module pipe_payload_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - valid/ready inter-stage register with optional skid entry,
// flush, bubble masking of control bits and a saturating stall counter
module pipe_stage_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_CH  = 2,
    parameter int CTRL_W  = 2,
    parameter int REG_W   = 5,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic [REG_W-1:0]         in_reg,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [REG_W-1:0]         out_reg,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int PW = payload_w(REG_W, CTRL_W, NUM_CH, DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pipe_state_e      state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             in_fire, out_fire;
    logic             main_load, skid_load, main_from_skid;
    logic [PW-1:0]    in_pl, main_pl_d, main_pl, skid_pl;
    logic [CTRL_W-1:0] main_ctrl;

    assign in_pl     = {in_ctrl, in_reg, in_data};
    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    generate
        if (SKID_EN != 0) begin : g_ready_reg
            assign in_ready = in_ready_q;
        end else begin : g_ready_comb
            assign in_ready = !out_valid | out_ready;
        end
    endgenerate

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            // Payload registers keep their contents; only occupancy is dropped.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d   = ST_ONE;
                        main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire && (SKID_EN != 0)) begin
                        state_d   = ST_FULL;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d        = ST_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        in_ready_d = (state_d != ST_FULL);

        stall_cnt_d = stall_cnt_q;
        if (in_valid && !in_ready && !flush && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end

        main_pl_d = main_from_skid ? skid_pl : in_pl;
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    pipe_payload_reg #(.W(PW)) u_main (
        .clk  (CLK),
        .clr  (rst),
        .load (main_load),
        .d    (main_pl_d),
        .q    (main_pl)
    );

    generate
        if (SKID_EN != 0) begin : g_skid
            pipe_payload_reg #(.W(PW)) u_skid (
                .clk  (CLK),
                .clr  (rst),
                .load (skid_load),
                .d    (in_pl),
                .q    (skid_pl)
            );
        end else begin : g_no_skid
            assign skid_pl = '0;
        end
    endgenerate

    assign {main_ctrl, out_reg, out_data} = main_pl;
    assign out_ctrl  = main_ctrl & {CTRL_W{out_valid}};
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb/tb_pipe_stage_skid_reg.sv - bench for pipe_stage_skid_reg, skid and no-skid instances
module tb_pipe_stage_skid_reg;

    localparam int PW = 71;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst, flush, in_valid, out_ready;
    logic [1:0]  in_ctrl;
    logic [4:0]  in_reg;
    logic [63:0] in_data;

    logic        a_in_ready, a_out_valid;
    logic [1:0]  a_out_ctrl;
    logic [4:0]  a_out_reg;
    logic [63:0] a_out_data;
    logic [15:0] a_stall;

    logic        b_in_ready, b_out_valid;
    logic [1:0]  b_out_ctrl;
    logic [4:0]  b_out_reg;
    logic [63:0] b_out_data;
    logic [1:0]  b_stall;

    pipe_stage_skid_reg #(.SKID_EN(1), .CNT_W(16)) dut_a (
        .CLK(CLK), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_ctrl(in_ctrl), .in_reg(in_reg), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_ctrl(a_out_ctrl), .out_reg(a_out_reg), .out_data(a_out_data),
        .stall_cnt(a_stall)
    );

    pipe_stage_skid_reg #(.SKID_EN(0), .CNT_W(2)) dut_b (
        .CLK(CLK), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_ctrl(in_ctrl), .in_reg(in_reg), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_ctrl(b_out_ctrl), .out_reg(b_out_reg), .out_data(b_out_data),
        .stall_cnt(b_stall)
    );

    // Reference: each instance is a FIFO of capacity 2 (skid) or 1 (no skid).
    logic [PW-1:0] m_ent  [2][2];
    int            m_cnt  [2];
    logic [PW-1:0] m_main [2];
    int            m_stall[2];
    int            m_max  [2];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic m_rdy(input int i);
        if (i == 0) return (m_cnt[0] < 2);
        return (m_cnt[1] == 0) || out_ready;
    endfunction

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            logic [PW-1:0] mp;
            logic          ov, ir;
            logic [1:0]    oc;
            logic [4:0]    orr;
            logic [63:0]   od;
            logic [15:0]   sc;
            mp = (m_cnt[i] > 0) ? m_ent[i][0] : m_main[i];
            if (i == 0) begin
                ov = a_out_valid; ir = a_in_ready; oc = a_out_ctrl;
                orr = a_out_reg; od = a_out_data; sc = a_stall;
            end else begin
                ov = b_out_valid; ir = b_in_ready; oc = b_out_ctrl;
                orr = b_out_reg; od = b_out_data; sc = {14'd0, b_stall};
            end
            chk($sformatf("i%0d out_valid", i), ov, (m_cnt[i] > 0));
            chk($sformatf("i%0d in_ready", i), ir, m_rdy(i));
            chk($sformatf("i%0d out_ctrl", i), oc, (m_cnt[i] > 0) ? mp[70:69] : 2'b00);
            chk($sformatf("i%0d out_reg", i), orr, mp[68:64]);
            chk($sformatf("i%0d out_data", i), od, mp[63:0]);
            chk($sformatf("i%0d stall_cnt", i), sc, m_stall[i]);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_cnt[i]   = 0;
                m_main[i]  = '0;
                m_stall[i] = 0;
            end else begin
                logic rdy, fin, fout;
                rdy  = m_rdy(i);
                fin  = in_valid && rdy;
                fout = (m_cnt[i] > 0) && out_ready;
                if (in_valid && !rdy && !flush && m_stall[i] < m_max[i]) m_stall[i]++;
                if (flush) begin
                    m_cnt[i] = 0;
                end else begin
                    if (fout) begin
                        m_ent[i][0] = m_ent[i][1];
                        m_cnt[i]--;
                    end
                    if (fin) begin
                        m_ent[i][m_cnt[i]] = {in_ctrl, in_reg, in_data};
                        m_cnt[i]++;
                    end
                    if (m_cnt[i] > 0) m_main[i] = m_ent[i][0];
                end
            end
        end
    endtask

    task automatic step();
        @(negedge CLK);
        check_outputs();
        model_update();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        m_max[0] = 65535;
        m_max[1] = 3;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_main[i] = '0; m_stall[i] = 0;
            m_ent[i][0] = '0; m_ent[i][1] = '0;
        end
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_ctrl = 2'b11; in_reg = 5'd3; in_data = 64'h1234;
        @(posedge CLK);
        #1;

        // Reset held with traffic and a flush that must be ignored
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        rst = 1'b0;

        // Full-rate stream
        out_ready = 1'b1;
        in_reg    = 5'd9;
        in_data   = {32'hDEAD_BEEF, 32'h0000_0005};
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_ctrl  = 2'(k);
            step();
        end
        in_valid = 1'b0;
        step();
        step();

        // Backpressure with A, B, C then release
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_reg   = 5'(10 + (k > 2 ? 2 : k));
            in_ctrl  = 2'((k > 2 ? 2 : k) + 1);
            in_data  = {$urandom, $urandom};
            if (k == 3) in_data = {32'hC0C0_C0C0, 32'h0000_000C};
            step();
        end
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();

        // Flush while full, with a valid input that must be discarded
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_ctrl = 2'b01; in_reg = 5'(20 + k); in_data = {$urandom, $urandom};
            step();
        end
        flush = 1'b1; in_valid = 1'b1; in_ctrl = 2'b11; in_reg = 5'd31; in_data = 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) step();

        // Stall counter saturation from a clean start
        rst = 1'b1;
        step();
        rst = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 2'b10;
        for (int k = 0; k < 6; k++) begin
            in_reg = 5'(k); in_data = {$urandom, $urandom};
            step();
        end
        out_ready = 1'b1; in_valid = 1'b0;
        for (int k = 0; k < 3; k++) step();

        // Reset while full: held entries must never emerge
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_ctrl = 2'b11; in_reg = 5'(25 + k); in_data = {$urandom, $urandom};
            step();
        end
        rst = 1'b1; in_valid = 1'b0;
        step();
        rst = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) step();

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            rst       = ($urandom % 64) == 0;
            flush     = ($urandom % 16) == 0;
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            in_ctrl   = 2'($urandom);
            in_reg    = 5'($urandom);
            in_data   = {$urandom, $urandom};
            step();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
